au_core: RTL and testbench

Fixed-point arithmetic unit on the responder side of the sequencer's AU handshake.
- It accepts a 1-cycle `start` with an op code (sequencer field d, 2 bits) and two operands read from the data bank.
- It executes ADD, SUB, MUL or DIV and returns a registered result with a 1-cycle `continue_o` pulse, which wires to the sequencer's `continue_i`.
- ADD/SUB/MUL complete in one cycle; DIV is iterative, so the sequencer holds on a WAIT instruction until `continue_o` fires.

---
 rtl/au_core.sv | 197 +++++++++++++++++++
 tb/tb_au_core.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/au_core.sv
// Fixed-point add/sub/mul/div unit answering the sequencer's AU start/continue handshake.
// Build option: define AU_SAT_EN to clamp ADD/SUB/MUL overflow instead of wrapping.
module au_core #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] result,
    output logic             continue_o,
    output logic             busy,
    output logic             ovf,
    output logic             dz,
    output logic [1:0]       state_dbg
);

    localparam int Q  = WIDTH + FRAC;
    localparam int CW = $clog2(Q + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [WIDTH-1:0] MAX_V   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_V   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [Q-1:0]     POS_LIM = Q'((1 << (WIDTH-1)) - 1);
    localparam logic [Q-1:0]     NEG_LIM = Q'(1 << (WIDTH-1));

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DIV_FIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Handshake: start is honoured only in IDLE (busy=0); each completion
    // raises continue_o for exactly one cycle alongside the registered result.
    logic accept;
    assign accept    = start && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    // Division datapath: quo_q starts as the dividend and shifts quotient bits in.
    logic [Q-1:0]     quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic             a_neg_q;
    logic             dz_q;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   trial_rem;
    logic             trial_ge;

    assign abs_a     = opa[WIDTH-1] ? (-opa) : opa;
    assign abs_b     = opb[WIDTH-1] ? (-opb) : opb;
    assign trial_rem = {rem_q, quo_q[Q-1]};
    assign trial_ge  = (trial_rem >= {1'b0, dsr_q});

    // Single-cycle ALU for ADD/SUB/MUL
    logic [WIDTH:0]           sum_w;
    logic signed [2*WIDTH-1:0] prod_w, prod_sh;
    logic [WIDTH-1:0]         alu_raw, alu_sat, alu_res;
    logic                     alu_ovf;

    always_comb begin
        sum_w   = '0;
        prod_w  = '0;
        prod_sh = '0;
        alu_raw = '0;
        alu_sat = '0;
        alu_ovf = 1'b0;
        alu_res = '0;
        if (op == OP_SUB)
            sum_w = {opa[WIDTH-1], opa} - {opb[WIDTH-1], opb};
        else
            sum_w = {opa[WIDTH-1], opa} + {opb[WIDTH-1], opb};
        prod_w  = $signed({{WIDTH{opa[WIDTH-1]}}, opa}) * $signed({{WIDTH{opb[WIDTH-1]}}, opb});
        prod_sh = prod_w >>> FRAC;
        if (op == OP_MUL) begin
            alu_raw = prod_sh[WIDTH-1:0];
            alu_sat = prod_sh[2*WIDTH-1] ? MIN_V : MAX_V;
            alu_ovf = !((&prod_sh[2*WIDTH-1:WIDTH-1]) || !(|prod_sh[2*WIDTH-1:WIDTH-1]));
        end else begin
            alu_raw = sum_w[WIDTH-1:0];
            alu_sat = sum_w[WIDTH] ? MIN_V : MAX_V;
            alu_ovf = sum_w[WIDTH] ^ sum_w[WIDTH-1];
        end
`ifdef AU_SAT_EN
        alu_res = alu_ovf ? alu_sat : alu_raw;
`else
        alu_res = alu_raw;
`endif
    end

    // Final signing and clamping of the division result (clamps in every build)
    logic [WIDTH-1:0] fin_res;
    logic             fin_ovf;

    always_comb begin
        fin_res = '0;
        fin_ovf = 1'b0;
        if (dz_q) begin
            fin_res = a_neg_q ? MIN_V : MAX_V;
        end else if (!neg_q && (quo_q > POS_LIM)) begin
            fin_res = MAX_V;
            fin_ovf = 1'b1;
        end else if (neg_q && (quo_q > NEG_LIM)) begin
            fin_res = MIN_V;
            fin_ovf = 1'b1;
        end else begin
            fin_res = neg_q ? (-quo_q[WIDTH-1:0]) : quo_q[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && (op == OP_DIV))
                    state_d = (opb == '0) ? DIV_FIN : DIV_RUN;
            end
            DIV_RUN: begin
                if (cnt_q == CW'(1))
                    state_d = DIV_FIN;
            end
            DIV_FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result     <= '0;
            continue_o <= 1'b0;
            ovf        <= 1'b0;
            dz         <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            dsr_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            a_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            continue_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && (op != OP_DIV)) begin
                        result     <= alu_res;
                        ovf        <= alu_ovf;
                        dz         <= 1'b0;
                        continue_o <= 1'b1;
                    end else if (accept) begin
                        quo_q   <= {abs_a, {FRAC{1'b0}}};
                        rem_q   <= '0;
                        dsr_q   <= abs_b;
                        neg_q   <= opa[WIDTH-1] ^ opb[WIDTH-1];
                        a_neg_q <= opa[WIDTH-1];
                        dz_q    <= (opb == '0);
                        cnt_q   <= CW'(Q);
                    end
                end
                DIV_RUN: begin
                    if (trial_ge)
                        rem_q <= WIDTH'(trial_rem - {1'b0, dsr_q});
                    else
                        rem_q <= trial_rem[WIDTH-1:0];
                    quo_q <= {quo_q[Q-2:0], trial_ge};
                    cnt_q <= cnt_q - CW'(1);
                end
                DIV_FIN: begin
                    result     <= fin_res;
                    ovf        <= fin_ovf;
                    dz         <= dz_q;
                    continue_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_au_core.sv
// Randomised scoreboard bench for au_core: driver pushes expected results, a
// negedge monitor pops and compares them whenever continue_o fires.
module tb_au_core;

    localparam int W    = 16;
    localparam int FRAC = 8;
    localparam int Q    = W + FRAC;
    localparam longint MAXI = (longint'(1) <<< (W-1)) - 1;
    localparam longint MINI = -(longint'(1) <<< (W-1));
`ifdef AU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start;
    logic [1:0]   op;
    logic [W-1:0] opa, opb, result;
    logic         continue_o, busy, ovf, dz;
    logic [1:0]   state_dbg;

    au_core #(.WIDTH(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .result(result), .continue_o(continue_o), .busy(busy), .ovf(ovf), .dz(dz),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W+1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           checks = 0;
    int           failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the signed operand values
    function automatic logic [W+1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, v;
        logic ov, z;
        logic [W-1:0] res;
        sa = $signed(a);
        sb = $signed(b);
        z  = 1'b0;
        case (o)
            2'd0: v = sa + sb;
            2'd1: v = sa - sb;
            2'd2: v = (sa * sb) >>> FRAC;
            default: begin
                if (sb == 0) begin
                    z = 1'b1;
                    v = (sa >= 0) ? MAXI : MINI;
                end else begin
                    v = (sa * (longint'(1) <<< FRAC)) / sb;
                end
            end
        endcase
        ov  = !z && ((v > MAXI) || (v < MINI));
        res = v[W-1:0];
        if (ov && (o == 2'd3 || SAT))
            res = (v > MAXI) ? MAXI[W-1:0] : MINI[W-1:0];
        return {res, ov, z};
    endfunction

    task automatic push_exp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int edge_n);
        int lat;
        lat = (o != 2'd3) ? 0 : ((b == '0) ? 1 : Q + 1);
        exp_q.push_back(model(o, a, b));
        exp_cyc_q.push_back(edge_n + lat);
    endtask

    task automatic send(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        start = 1'b1; op = o; opa = a; opb = b;
        push_exp(o, a, b, cyc + 1);
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); opa = W'($urandom); opb = W'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL completion_timeout: pending %0d expected 0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    // Monitor
    logic [W+1:0] mon_e;
    int           mon_c;
    always @(negedge clk) begin
        if (!rst && continue_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: continue_o=1 result=%0h expected no pulse", result);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("result", 32'(result), 32'(mon_e[W+1:2]));
                check("ovf_dz", {30'd0, ovf, dz}, {30'd0, mon_e[1:0]});
                check("latency", 32'(cyc), 32'(mon_c));
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] corners[8];
        corners = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0100, 16'hFF00, 16'h0001, 16'hFFFF, 16'h7F00};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 7)];
        return W'($urandom);
    endfunction

    initial begin
        int bad;
        logic [1:0] o;
        logic [W-1:0] a, b;
        rst = 1'b1; start = 1'b0; op = 2'd0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {10'd0, result, continue_o, busy, ovf, dz, state_dbg}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed values from the datasheet examples
        send(2'd0, 16'h0180, 16'h0200);
        send(2'd2, 16'h0180, 16'h0200);
        send(2'd3, 16'h0300, 16'h0200);
        bad = 0;
        for (int i = 0; i < Q - 1; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) bad++;
        end
        check("busy_during_div", 32'(bad), 32'd0);
        wait_idle();
        send(2'd3, 16'hFE80, 16'h0200);
        wait_idle();
        send(2'd3, 16'h0100, 16'h0000);
        wait_idle();
        send(2'd3, 16'hFF00, 16'h0000);
        wait_idle();
        send(2'd0, 16'h7F00, 16'h0200);
        send(2'd1, 16'h8000, 16'h0001);
        send(2'd2, 16'h4000, 16'h4000);
        send(2'd3, 16'h7FFF, 16'h0001);
        wait_idle();

        // Start re-pulsed while a divide is in flight must be ignored
        send(2'd3, 16'h0500, 16'h0300);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; op = 2'd0; opa = W'($urandom); opb = W'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // Reset in the middle of a divide aborts with no pulse
        send(2'd0, 16'h0100, 16'h0100);
        send(2'd3, 16'h0300, 16'h0200);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
        check("abort_outputs", {10'd0, result, continue_o, busy, ovf, dz, state_dbg}, 32'd0);
        repeat (30) @(negedge clk);

        // Back-to-back: new ADD issued in the cycle continue_o is high
        send(2'd3, 16'h0300, 16'h0200);
        for (int i = 0; i < 40 && !continue_o; i++) @(negedge clk);
        checks++;
        if (!continue_o) begin
            failures++;
            $display("FAIL b2b_wait: continue_o=0 expected 1");
        end
        start = 1'b1; op = 2'd0; opa = 16'h0040; opb = 16'h0020;
        push_exp(2'd0, 16'h0040, 16'h0020, cyc + 1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // Randomised traffic
        for (int n = 0; n < 200; n++) begin
            o = 2'($urandom_range(0, 3));
            a = rand_operand();
            b = rand_operand();
            if (o == 2'd3 && $urandom_range(0, 9) == 0) b = '0;
            send(o, a, b);
            if (o == 2'd3) wait_idle();
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
